// File: rtl/sync_blank_pkg.sv
// Shared types and defaults for the raster-timing recovery block.
package sync_blank_pkg;

  localparam int unsigned DEF_CNT_W      = 11;
  localparam int unsigned DEF_LOCK_LINES = 4;

  typedef enum logic [1:0] {
    UNLOCKED,
    TRACKING,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/sync_line_meter.sv
// Line-length capture and raster lock tracker, driven by the hs rising edge.
module sync_line_meter
  import sync_blank_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned LOCK_LINES = DEF_LOCK_LINES
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             hs_rise,
  input  logic [CNT_W-1:0] pcnt,
  output logic [CNT_W-1:0] line_len,
  output logic             locked
);

  localparam int unsigned MW = $clog2(LOCK_LINES + 1);
  localparam logic [MW-1:0] ONE_C  = MW'(1);
  localparam logic [MW-1:0] LOCK_C = MW'(LOCK_LINES);

  lock_state_t      state;
  logic [MW-1:0]    match_cnt;
  logic [CNT_W-1:0] capture;
  logic             pcnt_sat;
  logic             same;

  assign pcnt_sat = &pcnt;
  // The edge cycle itself belongs to the finished line, hence pcnt+1.
  assign capture  = pcnt_sat ? pcnt : pcnt + 1'b1;
  assign same     = (capture == line_len);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UNLOCKED;
      match_cnt <= '0;
      line_len  <= '0;
      locked    <= 1'b0;
    end else begin
      if (hs_rise)
        line_len <= capture;
      if (pcnt_sat) begin
        state     <= UNLOCKED;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else if (hs_rise) begin
        case (state)
          UNLOCKED: begin
            state     <= TRACKING;
            match_cnt <= ONE_C;
          end
          TRACKING: begin
            if (same) begin
              match_cnt <= match_cnt + ONE_C;
              if (match_cnt + ONE_C >= LOCK_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= ONE_C;
            end
          end
          LOCKED: begin
            if (!same) begin
              state     <= UNLOCKED;
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          end
          default: begin
            state     <= UNLOCKED;
            match_cnt <= '0;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/sync_blank_gen.sv
// Raster-timing recovery: pixel enable, registered blanks, beam counters.
// Line measurement and lock are built only when SYNC_MEASURE_EN is defined.
module sync_blank_gen
  import sync_blank_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned CE_LOG     = 1,
  parameter int unsigned H_START    = 40,
  parameter int unsigned H_END      = 336,
  parameter int unsigned V_START    = 6,
  parameter int unsigned V_END      = 246,
  parameter int unsigned LOCK_LINES = DEF_LOCK_LINES
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    hs,
  input  logic                    vs,
  output logic                    ce_pix,
  output logic                    hblank,
  output logic                    vblank,
  output logic                    de,
  output logic [CNT_W-CE_LOG-1:0] hcount,
  output logic [CNT_W-1:0]        vcount,
  output logic [CNT_W-1:0]        line_len,
  output logic                    locked
);

  localparam int unsigned HW = CNT_W - CE_LOG;
  localparam logic [HW-1:0]    H_START_C = HW'(H_START);
  localparam logic [HW-1:0]    H_END_C   = HW'(H_END);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_END);

  if (H_START == H_END) begin : g_bad_h
    $error("sync_blank_gen: H_START must differ from H_END");
  end
  if (V_START == V_END) begin : g_bad_v
    $error("sync_blank_gen: V_START must differ from V_END");
  end

  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] lcnt;
  logic             old_hs;
  logic             old_vs;
  logic             hs_rise;
  logic             vs_rise;

  assign hs_rise = hs & ~old_hs;
  assign vs_rise = vs & ~old_vs;
  assign ce_pix  = &pcnt[CE_LOG-1:0];
  assign hcount  = pcnt[CNT_W-1:CE_LOG];
  assign vcount  = lcnt;
  assign de      = ~(hblank | vblank);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pcnt   <= '0;
      lcnt   <= '0;
      old_hs <= 1'b0;
      old_vs <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
    end else begin
      old_hs <= hs;
      if (hs_rise)
        pcnt <= '0;
      else if (!(&pcnt))
        pcnt <= pcnt + 1'b1;
      // vs only matters at line starts; a frame start overrides the line step.
      if (hs_rise) begin
        old_vs <= vs;
        if (vs_rise)
          lcnt <= '0;
        else if (!(&lcnt))
          lcnt <= lcnt + 1'b1;
      end
      if (hcount == H_START_C)
        hblank <= 1'b0;
      else if (hcount == H_END_C)
        hblank <= 1'b1;
      if (lcnt == V_START_C)
        vblank <= 1'b0;
      else if (lcnt == V_END_C)
        vblank <= 1'b1;
    end
  end

`ifdef SYNC_MEASURE_EN
  sync_line_meter #(
    .CNT_W     (CNT_W),
    .LOCK_LINES(LOCK_LINES)
  ) u_meter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .hs_rise (hs_rise),
    .pcnt    (pcnt),
    .line_len(line_len),
    .locked  (locked)
  );
`else
  assign line_len = '0;
  assign locked   = 1'b1;
`endif

endmodule
